// File: rtl/pic_host_bus_master.sv
// rtl/pic_host_bus_master.sv - host-side bus master for the 8259A: init/EOI write cycles and 8086 INTA acknowledge
//
// Purpose: issues the ICW1..ICW4/OCW1 programming writes and OCW2 EOI writes to the PIC, and
//          answers INT with the two-pulse INTA handshake, capturing the vector driven on D_IN.
// Ports:
//    clk, reset                  rising-edge clock, asynchronous active-high reset
//    init_start, icw1..4, ocw1   start programming sequence with the given words
//    eoi_req, eoi_cmd            request one OCW2 write with the given byte
//    INT, D_IN                   PIC interrupt request and vector bus
//    CS_n, WR_n, A0, D_OUT, D_OE PIC write interface
//    INTA_n                      interrupt acknowledge strobe
//    vector, vector_valid        last captured vector and its one-cycle update pulse
//    init_done, busy             programming complete / FSM not idle
module pic_host_bus_master #(
   parameter int WR_WIDTH   = 2,
   parameter int INTA_WIDTH = 2,
   parameter int INTA_GAP   = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       init_start,
   input  logic [7:0] icw1,
   input  logic [7:0] icw2,
   input  logic [7:0] icw3,
   input  logic [7:0] icw4,
   input  logic [7:0] ocw1,
   input  logic       eoi_req,
   input  logic [7:0] eoi_cmd,
   input  logic       INT,
   input  logic [7:0] D_IN,
   output logic       CS_n,
   output logic       WR_n,
   output logic       A0,
   output logic [7:0] D_OUT,
   output logic       D_OE,
   output logic       INTA_n,
   output logic [7:0] vector,
   output logic       vector_valid,
   output logic       init_done,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_W_SETUP, S_W_STROBE, S_W_HOLD, S_INTA1, S_GAP, S_INTA2, S_RECOVER
   } state_t;

   // Init word steps: 0=ICW1 1=ICW2 2=ICW3 3=ICW4 4=OCW1
   localparam logic [2:0] STEP_OCW1 = 3'd4;

   state_t     r_state, w_next;
   logic [7:0] r_cnt;
   logic [7:0] r_icw1, r_icw2, r_icw3, r_icw4, r_ocw1;
   logic [2:0] r_step, w_step_nxt;
   logic [7:0] w_next_word;
   logic       r_in_init, r_init_done, r_eoi_pend, r_a0, r_vv;
   logic [7:0] r_eoi_cmd, r_dout, r_vector;
   logic       w_start_init, w_start_eoi, w_next_write, w_init_fin, w_capture;
   logic       w_eoi_pend, w_wr_last, w_inta_last, w_gap_last;

   assign w_wr_last   = (r_cnt == 8'(WR_WIDTH - 1));
   assign w_inta_last = (r_cnt == 8'(INTA_WIDTH - 1));
   assign w_gap_last  = (r_cnt == 8'(INTA_GAP - 1));
   // A request arriving this cycle competes in arbitration as if already pending
   assign w_eoi_pend  = r_eoi_pend | eoi_req;

   assign A0           = r_a0;
   assign D_OUT        = r_dout;
   assign vector       = r_vector;
   assign vector_valid = r_vv;
   assign init_done    = r_init_done;
   assign busy         = (r_state != S_IDLE);

   // ICW3 only in cascade mode (icw1[1]==0), ICW4 only when IC4 (icw1[0]==1)
   always_comb begin
      w_step_nxt = STEP_OCW1;
      case (r_step)
         3'd0:    w_step_nxt = 3'd1;
         3'd1:    w_step_nxt = !r_icw1[1] ? 3'd2 : (r_icw1[0] ? 3'd3 : STEP_OCW1);
         3'd2:    w_step_nxt = r_icw1[0] ? 3'd3 : STEP_OCW1;
         default: w_step_nxt = STEP_OCW1;
      endcase
   end

   always_comb begin
      w_next_word = r_ocw1;
      case (w_step_nxt)
         3'd1:    w_next_word = r_icw2;
         3'd2:    w_next_word = r_icw3;
         3'd3:    w_next_word = r_icw4;
         default: w_next_word = r_ocw1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_start_init = 1'b0;
      w_start_eoi  = 1'b0;
      w_next_write = 1'b0;
      w_init_fin   = 1'b0;
      w_capture    = 1'b0;
      CS_n         = 1'b1;
      WR_n         = 1'b1;
      D_OE         = 1'b0;
      INTA_n       = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (init_start) begin
               w_start_init = 1'b1;
               w_next       = S_W_SETUP;
            end else if (w_eoi_pend && r_init_done) begin
               w_start_eoi = 1'b1;
               w_next      = S_W_SETUP;
            end else if (INT && r_init_done) begin
               w_next = S_INTA1;
            end
         end
         S_W_SETUP: begin
            CS_n   = 1'b0;
            D_OE   = 1'b1;
            w_next = S_W_STROBE;
         end
         S_W_STROBE: begin
            CS_n = 1'b0;
            D_OE = 1'b1;
            WR_n = 1'b0;
            if (w_wr_last) w_next = S_W_HOLD;
         end
         S_W_HOLD: begin
            CS_n = 1'b0;
            D_OE = 1'b1;
            if (r_in_init && (r_step != STEP_OCW1)) begin
               w_next_write = 1'b1;
               w_next       = S_W_SETUP;
            end else begin
               w_init_fin = r_in_init;
               w_next     = S_IDLE;
            end
         end
         S_INTA1: begin
            INTA_n = 1'b0;
            if (w_inta_last) w_next = S_GAP;
         end
         S_GAP: begin
            if (w_gap_last) w_next = S_INTA2;
         end
         S_INTA2: begin
            INTA_n = 1'b0;
            if (w_inta_last) begin
               w_capture = 1'b1;
               w_next    = S_RECOVER;
            end
         end
         S_RECOVER: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_icw1      <= 8'd0;
         r_icw2      <= 8'd0;
         r_icw3      <= 8'd0;
         r_icw4      <= 8'd0;
         r_ocw1      <= 8'd0;
         r_step      <= 3'd0;
         r_in_init   <= 1'b0;
         r_init_done <= 1'b0;
         r_eoi_pend  <= 1'b0;
         r_eoi_cmd   <= 8'd0;
         r_a0        <= 1'b0;
         r_dout      <= 8'd0;
         r_vv        <= 1'b0;
         r_vector    <= 8'd0;
      end else begin
         if (eoi_req) r_eoi_cmd <= eoi_cmd;
         // A request in the same cycle the write launches is served by that write
         if (w_start_eoi)  r_eoi_pend <= 1'b0;
         else if (eoi_req) r_eoi_pend <= 1'b1;

         if (w_start_init) begin
            r_icw1      <= icw1;
            r_icw2      <= icw2;
            r_icw3      <= icw3;
            r_icw4      <= icw4;
            r_ocw1      <= ocw1;
            r_step      <= 3'd0;
            r_in_init   <= 1'b1;
            r_init_done <= 1'b0;
            r_a0        <= 1'b0;
            r_dout      <= icw1;
         end else if (w_start_eoi) begin
            r_a0   <= 1'b0;
            r_dout <= eoi_req ? eoi_cmd : r_eoi_cmd;
         end else if (w_next_write) begin
            r_step <= w_step_nxt;
            r_a0   <= 1'b1;
            r_dout <= w_next_word;
         end else if (w_init_fin) begin
            r_in_init   <= 1'b0;
            r_init_done <= 1'b1;
         end

         r_vv <= w_capture;
         if (w_capture) r_vector <= D_IN;
      end
   end

endmodule

// File: tb/tb_pic_host_bus_master.sv
// tb/tb_pic_host_bus_master.sv - randomized directed bench for pic_host_bus_master against a queue-based reference model
module tb_pic_host_bus_master;

   localparam int WR_WIDTH   = 2;
   localparam int INTA_WIDTH = 2;
   localparam int INTA_GAP   = 1;
   localparam int WR_CYC     = WR_WIDTH + 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       init_start, eoi_req, INT;
   logic [7:0] icw1, icw2, icw3, icw4, ocw1, eoi_cmd, D_IN;
   logic       CS_n, WR_n, A0, D_OE, INTA_n, vector_valid, init_done, busy;
   logic [7:0] D_OUT, vector;

   pic_host_bus_master #(
      .WR_WIDTH(WR_WIDTH), .INTA_WIDTH(INTA_WIDTH), .INTA_GAP(INTA_GAP)
   ) dut (
      .clk(clk), .reset(reset), .init_start(init_start),
      .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .ocw1(ocw1),
      .eoi_req(eoi_req), .eoi_cmd(eoi_cmd), .INT(INT), .D_IN(D_IN),
      .CS_n(CS_n), .WR_n(WR_n), .A0(A0), .D_OUT(D_OUT), .D_OE(D_OE),
      .INTA_n(INTA_n), .vector(vector), .vector_valid(vector_valid),
      .init_done(init_done), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       a0;
      logic [7:0] d;
      int         len;
      int         st;
   } rec_t;

   int   n_vec = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   viol = 0;
   int   cs_falls = 0;
   int   cs_first = -1;
   int   done_cyc = -1;
   rec_t wq[$];
   rec_t iq[$];
   rec_t vq[$];
   logic [8:0] exp_wr[$];

   // Pulse recorder: write strobes, INTA pulses and vector_valid pulses, plus protocol checks
   rec_t wr_cur, ia_cur, vv_cur;
   int   wr_len = 0, ia_len = 0, vv_len = 0;
   logic prev_cs = 1'b1, prev_done = 1'b0;
   always @(negedge clk) begin
      cyc++;
      if (WR_n === 1'b0 && CS_n !== 1'b0) viol++;
      if (INTA_n === 1'b0 && (CS_n !== 1'b1 || WR_n !== 1'b1)) viol++;
      if (CS_n === 1'b0 && D_OE !== 1'b1) viol++;
      if (WR_n === 1'b0) begin
         if (wr_len == 0) begin
            wr_cur.a0 = A0; wr_cur.d = D_OUT; wr_cur.st = cyc;
         end else if (A0 !== wr_cur.a0 || D_OUT !== wr_cur.d) viol++;
         wr_len++;
      end else if (wr_len != 0) begin
         wr_cur.len = wr_len; wq.push_back(wr_cur); wr_len = 0;
      end
      if (INTA_n === 1'b0) begin
         if (ia_len == 0) begin
            ia_cur.a0 = 1'b0; ia_cur.d = 8'd0; ia_cur.st = cyc;
         end
         ia_len++;
      end else if (ia_len != 0) begin
         ia_cur.len = ia_len; iq.push_back(ia_cur); ia_len = 0;
      end
      if (vector_valid === 1'b1) begin
         if (vv_len == 0) begin
            vv_cur.a0 = 1'b0; vv_cur.d = vector; vv_cur.st = cyc;
         end
         vv_len++;
      end else if (vv_len != 0) begin
         vv_cur.len = vv_len; vq.push_back(vv_cur); vv_len = 0;
      end
      if (prev_cs === 1'b1 && CS_n === 1'b0) begin
         cs_falls++;
         if (cs_first < 0) cs_first = cyc;
      end
      if (prev_done === 1'b0 && init_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
      prev_cs   = CS_n;
      prev_done = init_done;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: the write list follows directly from the ICW1 mode bits
   task automatic build_init(input logic [7:0] w1, w2, w3, w4, o1);
      exp_wr.delete();
      exp_wr.push_back({1'b0, w1});
      exp_wr.push_back({1'b1, w2});
      if (w1[1] == 1'b0) exp_wr.push_back({1'b1, w3});
      if (w1[0] == 1'b1) exp_wr.push_back({1'b1, w4});
      exp_wr.push_back({1'b1, o1});
   endtask

   task automatic clear_rec();
      wq.delete(); iq.delete(); vq.delete();
      cs_falls = 0; cs_first = -1; done_cyc = -1;
   endtask

   task automatic wait_quiet();
      int quiet = 0;
      bit to = 1'b1;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk); #1;
         quiet = (busy === 1'b0) ? quiet + 1 : 0;
         if (quiet >= 4) begin to = 1'b0; break; end
      end
      chk("quiet_timeout", {31'd0, to}, 32'd0);
   endtask

   task automatic wait_vv();
      bit to = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk); #1;
         if (vector_valid === 1'b1) begin to = 1'b0; break; end
      end
      chk("vv_timeout", {31'd0, to}, 32'd0);
   endtask

   task automatic check_writes(input int nb2b);
      chk("wr_count", wq.size(), exp_wr.size());
      foreach (exp_wr[i]) begin
         if (i < wq.size()) begin
            chk("wr_a0", {31'd0, wq[i].a0}, {31'd0, exp_wr[i][8]});
            chk("wr_data", {24'd0, wq[i].d}, {24'd0, exp_wr[i][7:0]});
            chk("wr_len", wq[i].len, WR_WIDTH);
         end
      end
      for (int i = 1; i < nb2b && i < wq.size(); i++)
         chk("wr_spacing", wq[i].st - wq[i-1].st, WR_CYC);
      chk("protocol", viol, 0);
   endtask

   task automatic run_init(input logic [7:0] w1, w2, w3, w4, o1,
                           input bit with_eoi, input logic [7:0] ecmd);
      int nseq;
      build_init(w1, w2, w3, w4, o1);
      nseq = exp_wr.size();
      if (with_eoi) exp_wr.push_back({1'b0, ecmd});
      clear_rec();
      @(posedge clk); #1;
      icw1 = w1; icw2 = w2; icw3 = w3; icw4 = w4; ocw1 = o1;
      init_start = 1'b1;
      @(posedge clk); #1;
      init_start = 1'b0;
      icw1 = 8'($urandom); icw2 = 8'($urandom);
      if (with_eoi) begin
         @(posedge clk); #1;
         eoi_req = 1'b1; eoi_cmd = ecmd;
         @(posedge clk); #1;
         eoi_req = 1'b0; eoi_cmd = 8'($urandom);
      end
      wait_quiet();
      chk("init_done", {31'd0, init_done}, 32'd1);
      chk("done_latency", done_cyc - cs_first, nseq * WR_CYC);
      chk("cs_falls", cs_falls, with_eoi ? 2 : 1);
      check_writes(nseq);
   endtask

   task automatic check_ack_pair(input int i0, input int v0, input logic [7:0] vexp);
      if (i0 + 1 < iq.size() && v0 < vq.size()) begin
         chk("inta1_len", iq[i0].len, INTA_WIDTH);
         chk("inta_gap", iq[i0+1].st - (iq[i0].st + iq[i0].len), INTA_GAP);
         chk("inta2_len", iq[i0+1].len, INTA_WIDTH);
         chk("vv_timing", vq[v0].st - iq[i0+1].st, INTA_WIDTH);
         chk("vv_len", vq[v0].len, 1);
         chk("vv_vector", {24'd0, vq[v0].d}, {24'd0, vexp});
      end else begin
         chk("ack_missing", 32'd0, 32'd1);
      end
   endtask

   logic [7:0] d1, d2, r1, ec;

   initial begin
      reset = 1'b1; init_start = 1'b0; eoi_req = 1'b0; INT = 1'b0;
      icw1 = 8'd0; icw2 = 8'd0; icw3 = 8'd0; icw4 = 8'd0; ocw1 = 8'd0;
      eoi_cmd = 8'd0; D_IN = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_CS_n", {31'd0, CS_n}, 32'd1);
      chk("rst_WR_n", {31'd0, WR_n}, 32'd1);
      chk("rst_INTA_n", {31'd0, INTA_n}, 32'd1);
      chk("rst_A0", {31'd0, A0}, 32'd0);
      chk("rst_D_OUT", {24'd0, D_OUT}, 32'd0);
      chk("rst_D_OE", {31'd0, D_OE}, 32'd0);
      chk("rst_vector", {24'd0, vector}, 32'd0);
      chk("rst_vv", {31'd0, vector_valid}, 32'd0);
      chk("rst_init_done", {31'd0, init_done}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;

      // Init sequences: single+IC4, cascade+IC4, single without IC4, then random modes
      run_init(8'h13, 8'h40, 8'($urandom), 8'h01, 8'hF0, 1'b0, 8'd0);
      run_init(8'h11, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 8'd0);
      run_init(8'h12, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 8'd0);
      for (int k = 0; k < 3; k++)
         run_init(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 8'd0);

      // Two back-to-back acknowledges while INT stays high, then INT drops
      clear_rec();
      d2 = 8'($urandom);
      @(posedge clk); #1;
      D_IN = 8'h48; INT = 1'b1;
      wait_vv();
      chk("vector_1", {24'd0, vector}, 32'h48);
      D_IN = d2;
      wait_vv();
      chk("vector_2", {24'd0, vector}, {24'd0, d2});
      INT = 1'b0;
      wait_quiet();
      chk("inta_pulses", iq.size(), 4);
      chk("vv_pulses", vq.size(), 2);
      check_ack_pair(0, 0, 8'h48);
      check_ack_pair(2, 1, d2);
      if (iq.size() > 2 && vq.size() > 0)
         chk("reack_spacing", iq[2].st - vq[0].st, 2);
      chk("ack_no_writes", wq.size(), 0);
      chk("vector_hold", {24'd0, vector}, {24'd0, d2});
      chk("protocol", viol, 0);

      // EOI and INT in the same idle cycle: OCW2 write wins, acknowledge follows
      clear_rec();
      d1 = 8'($urandom);
      @(posedge clk); #1;
      eoi_req = 1'b1; eoi_cmd = 8'h20; INT = 1'b1; D_IN = d1;
      @(posedge clk); #1;
      eoi_req = 1'b0; eoi_cmd = 8'($urandom);
      wait_vv();
      INT = 1'b0;
      wait_quiet();
      exp_wr.delete();
      exp_wr.push_back({1'b0, 8'h20});
      check_writes(1);
      chk("eoi_inta_pulses", iq.size(), 2);
      check_ack_pair(0, 0, d1);
      if (iq.size() > 0 && wq.size() > 0)
         chk("eoi_before_ack", {31'd0, (iq[0].st > wq[0].st + WR_WIDTH)}, 32'd1);

      // init_start during an acknowledge is ignored
      clear_rec();
      d1 = 8'($urandom);
      @(posedge clk); #1;
      INT = 1'b1; D_IN = d1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk); #1;
         if (INTA_n === 1'b0) break;
      end
      @(posedge clk); #1;
      icw1 = 8'($urandom); init_start = 1'b1;
      @(posedge clk); #1;
      init_start = 1'b0;
      wait_vv();
      INT = 1'b0;
      wait_quiet();
      chk("ign_writes", wq.size(), 0);
      chk("ign_init_done", {31'd0, init_done}, 32'd1);
      chk("ign_inta_pulses", iq.size(), 2);
      check_ack_pair(0, 0, d1);
      chk("ign_vector", {24'd0, vector}, {24'd0, d1});

      // EOI requested before init_done is held until the sequence completes
      r1 = 8'($urandom);
      ec = 8'($urandom);
      run_init(r1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, ec);

      // Asynchronous reset during the ICW2 strobe, then a fresh sequence
      clear_rec();
      @(posedge clk); #1;
      icw1 = 8'h13; icw2 = 8'h40; icw4 = 8'h01; ocw1 = 8'hF0; init_start = 1'b1;
      @(posedge clk); #1;
      init_start = 1'b0;
      begin
         bit to = 1'b1;
         for (int k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (WR_n === 1'b0 && A0 === 1'b1) begin to = 1'b0; break; end
         end
         chk("icw2_strobe_timeout", {31'd0, to}, 32'd0);
      end
      #2 reset = 1'b1;
      #1;
      chk("arst_WR_n", {31'd0, WR_n}, 32'd1);
      chk("arst_CS_n", {31'd0, CS_n}, 32'd1);
      chk("arst_D_OE", {31'd0, D_OE}, 32'd0);
      chk("arst_init_done", {31'd0, init_done}, 32'd0);
      chk("arst_vector", {24'd0, vector}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      run_init(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/pic_host_bus_master.md
Name: pic_host_bus_master

Overview:
- CPU-side bus agent for the 8259A PIC core. It generates the chip-select and write cycles that program ICW1..ICW4, OCW1 and the OCW2 EOI command.
- It also runs the two-pulse 8086-mode INTA acknowledge in response to INT and captures the vector the PIC drives.
- Sits between the system/testbench host and the PIC's bus-buffer/read-write pins, as the initiator counterpart of the control logic.

Parameters:
- WR_WIDTH, 2, cycles WR_n is held low per write (>=1)
- INTA_WIDTH, 2, cycles each INTA_n pulse is low (>=1)
- INTA_GAP, 1, cycles INTA_n is high between the two pulses (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-high reset
- init_start  input  1  one-cycle pulse; start the programming sequence
- icw1, icw2, icw3, icw4, ocw1  input  8 each  programming words, captured at init_start
- eoi_req  input  1  one-cycle pulse; request an OCW2 write
- eoi_cmd  input  8  OCW2 byte, captured with eoi_req
- INT  input  1  interrupt request from the PIC, level
- D_IN  input  8  data bus driven by the PIC during INTA
- CS_n  output  1  chip select, active low
- WR_n  output  1  write strobe, active low
- A0  output  1  address bit 0
- D_OUT  output  8  write data
- D_OE  output  1  write-data drive enable
- INTA_n  output  1  interrupt acknowledge, active low
- vector  output  8  last captured interrupt vector
- vector_valid  output  1  one-cycle pulse when vector updates
- init_done  output  1  programming sequence complete
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, immediate, including mid-cycle):
  - CS_n=1, WR_n=1, INTA_n=1, A0=0, D_OUT=0, D_OE=0, vector=0, vector_valid=0, init_done=0, busy=0.
  - Pending EOI flag cleared; FSM to IDLE.
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, INTA1, GAP, INTA2, RECOVER.
- Write cycle, total WR_WIDTH+2 cycles:
  - W_SETUP (1 cycle): CS_n=0, A0/D_OUT valid, D_OE=1, WR_n=1.
  - W_STROBE (WR_WIDTH cycles): adds WR_n=0.
  - W_HOLD (1 cycle): WR_n=1; CS_n, D_OE and data stay asserted.
  - After W_HOLD: next write starts in W_SETUP with no idle cycle, or the FSM returns to IDLE with CS_n=1 and D_OE=0.
- Init sequence, captured words:
  - ICW1 with A0=0, then ICW2 with A0=1.
  - ICW3 with A0=1 only if icw1[1]==0 (cascade).
  - ICW4 with A0=1 only if icw1[0]==1 (IC4).
  - OCW1 with A0=1.
  - init_done clears when the sequence starts and sets on the clock edge that ends the OCW1 W_HOLD.
- EOI:
  - eoi_req sets a pending flag, and eoi_cmd is latched even if the FSM is busy.
  - The OCW2 write uses A0=0 and clears the flag when it enters W_SETUP.
  - The write is only issued while init_done=1; before that the flag stays pending.
- Acknowledge (requires init_done=1):
  - INTA1: INTA_n=0 for INTA_WIDTH cycles.
  - GAP: INTA_n=1 for INTA_GAP cycles.
  - INTA2: INTA_n=0 for INTA_WIDTH cycles.
  - On the edge ending INTA2: vector<=D_IN, vector_valid=1 for the next cycle, INTA_n returns to 1.
  - RECOVER: 1 cycle, after which the FSM returns to IDLE. INT is re-evaluated only in IDLE.
  - CS_n=1 and WR_n=1 throughout the acknowledge.
- IDLE arbitration, same cycle: init_start > pending EOI > INT.
  - init_start while busy is ignored.
  - INT deasserting mid-acknowledge does not abort the sequence.
- vector holds its value until the next capture; it is never cleared except by reset.

Test Plan:
- Reset, then init_start with icw1=8'h13, icw2=8'h40, icw4=8'h01, ocw1=8'hF0:
  - Exactly 4 writes, each WR_WIDTH+2=4 cycles with no gaps between them.
  - Sequence: (A0=0,8'h13) (1,8'h40) (1,8'h01) (1,8'hF0).
  - init_done rises 16 cycles after sequence start; no write ever has CS_n=1 while WR_n=0.
- icw1=8'h11 (cascade, IC4): 5 writes with ICW3 third. icw1=8'h12: 3 writes, with ICW3 and ICW4 skipped.
- After init, INT=1 and D_IN=8'h48:
  - INTA_n pattern low2/high1/low2.
  - vector=8'h48 with a single-cycle vector_valid.
  - 1 RECOVER cycle, then IDLE; a second acknowledge follows only if INT is still 1.
- In IDLE, eoi_req with eoi_cmd=8'h20 and INT=1 in the same cycle:
  - OCW2 write (A0=0, 8'h20) completes first, then the INTA sequence.
  - eoi_req pulsed before init_done is held until init finishes.
- Assert reset during W_STROBE of ICW2:
  - WR_n and CS_n go to 1 and D_OE to 0 before the next clock edge; init_done=0.
  - A fresh init_start restarts from ICW1.
- Pulse init_start during an INTA sequence: it is ignored, and the acknowledge completes unchanged.
